mdu_iterative: RTL and testbench
================================

// Module: mdu_iterative
// PURPOSE
//  Iterative RV32M multiply/divide unit, parametrised in XLEN and bits-per-cycle. Sits beside the EX-stage ALU.
//  The hazard unit holds the pipeline (stall) while busy. Operands come in on a start pulse; the result is
//  returned with a one-cycle done pulse. Flushed by the branch/jump flush.
// PARAMETERS
//  XLEN    32  operand/result width; even, >= 8
//  UNROLL  1   iteration bits retired per cycle (1, 2 or 4); XLEN % UNROLL == 0
// PORTS
//  clk     in   1     rising-edge clock
//  rstn    in   1     asynchronous active-low reset
//  start   in   1     request; sampled only when accepting (IDLE or DONE state)
//  op      in   3     funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  a       in   XLEN  rs1 operand (multiplicand / dividend)
//  b       in   XLEN  rs2 operand (multiplier / divisor)
//  flush   in   1     abort current operation
//  busy    out  1     operation in flight; hazard unit asserts stall while high
//  done    out  1     one-cycle pulse; result valid
//  result  out  XLEN  product low/high word, quotient or remainder
// BEHAVIOUR
//  - Reset: async. busy=0, done=0, result=0, state=IDLE, counter=0, internal registers cleared. Applies mid-operation.
//  - States: IDLE -> BUSY -> DONE -> IDLE.
//    - DONE lasts exactly 1 cycle with done=1.
//    - start in DONE is accepted (back-to-back) and moves to BUSY, or straight to DONE for special cases.
//  - Accept: on a clock edge in IDLE/DONE with start=1 and flush=0, latch op and the operand magnitudes.
//    - Signed ops: |a| and |b| per op signedness. MULHSU treats only a as signed.
//    - Result signs are latched: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
//  - Iterations: N = XLEN/UNROLL cycles in BUSY; down-counter width clog2(N+1).
//    - MUL*: unsigned shift-add into a 2*XLEN accumulator.
//    - DIV*/REM*: restoring division on XLEN+1-bit partial remainder.
//  - Final cycle: result registers the sign-corrected value.
//    - MUL: low word. MULH/MULHSU/MULHU: high word.
//    - Negation is two's complement over 2*XLEN for products; over XLEN for quotient/remainder.
//  - Latency: start high in cycle 0 -> done high in cycle N+1 (33 for XLEN=32, UNROLL=1; 17 for UNROLL=2).
//  - Special cases, resolved at accept; DONE in cycle 1, no BUSY:
//    - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> a.
//    - Signed overflow (a = MIN, b = -1): DIV -> MIN; REM -> 0.
//  - busy = (state == BUSY). It is low in DONE so the pipeline advances in the done cycle.
//  - result holds its value from done until the next completion; it is not cleared on accept or flush.
//  - start while BUSY: ignored, no effect.
//  - flush: any state -> IDLE at the next edge; done stays 0 and counter is cleared.
//    - flush and start in the same cycle: flush wins, nothing accepted.
//    - flush in the DONE cycle: done already 1 that cycle; next state is IDLE.
//  - Operands are sampled only at accept. a/b may change freely during BUSY.
// STRUCTURE
//  - Shared package mdu_pkg:
//    - op encodings (MDU_MUL..MDU_REMU) and state enum (S_IDLE, S_BUSY, S_DONE)
//    - helpers is_div(op), is_signed_a(op), is_signed_b(op)
//  - Sub-module mdu_step (combinational): one radix-2 step, add-or-pass for multiply, trial-subtract for divide.
//    Chained UNROLL times inside mdu_iterative.
//  - Top: FSM, counter, operand/sign registers, special-case detect, sign-correction and output register.
// TESTING (XLEN=32 unless noted; cycle 0 = start cycle)
//  - MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB, done only in cycle 33, busy cycles 1-32.
//  - High words:
//    - MULH 0x80000000*0x80000000 -> 0x40000000
//    - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE
//    - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF
//  - Division:
//    - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF
//    - DIVU 100/7 -> 14; REMU -> 2
//  - Special cases, each with done in cycle 1 and busy never high:
//    - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5
//    - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0
//  - Control:
//    - flush in cycle 10 -> busy=0 from cycle 11, no done; prior result unchanged.
//    - start in cycle 5 while busy -> ignored, done still in cycle 33.
//    - back-to-back start in the done cycle -> second done in cycle 66.
//  - Reset and UNROLL:
//    - rstn low in cycle 12 -> busy/done/result 0 immediately (async, before the next edge).
//    - UNROLL=2: DIVU 0xFFFFFFFF/3 -> 0x55555555, done in cycle 17.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 encodings,
// FSM states and operand-signedness helpers.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } mdu_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
// The retained partial remainder is always below the divisor, so XLEN bits hold it.
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic            div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  always_comb begin
    sum     = {1'b0, hi_i} + {1'b0, opnd_i & {XLEN{lo_i[0]}}};
    shifted = {hi_i, lo_i[XLEN-1]};
    trial   = shifted - {1'b0, opnd_i};
    if (div_i) begin
      hi_o = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ~trial[XLEN]};
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: operates on magnitudes, retires UNROLL
// bits per cycle and sign-corrects the result in the final iteration.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);

  mdu_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic            prod_neg_q;
  logic            rem_neg_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] opnd_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic [UNROLL:0][XLEN-1:0] hi_c;
  logic [UNROLL:0][XLEN-1:0] lo_c;

  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  generate
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
      mdu_step #(.XLEN(XLEN)) u_step (
        .div_i (op_q[2]),
        .hi_i  (hi_c[gi]),
        .lo_i  (lo_c[gi]),
        .opnd_i(opnd_q),
        .hi_o  (hi_c[gi+1]),
        .lo_o  (lo_c[gi+1])
      );
    end
  endgenerate

  logic              sa_d;
  logic              sb_d;
  logic [XLEN-1:0]   mag_a_d;
  logic [XLEN-1:0]   mag_b_d;
  logic              div_zero_d;
  logic              div_ovf_d;
  logic [XLEN-1:0]   special_d;
  logic [2*XLEN-1:0] prod_d;
  logic [XLEN-1:0]   quot_d;
  logic [XLEN-1:0]   rem_d;
  logic [XLEN-1:0]   result_d;

  always_comb begin
    sa_d       = is_signed_a(op) & a[XLEN-1];
    sb_d       = is_signed_b(op) & b[XLEN-1];
    mag_a_d    = sa_d ? -a : a;
    mag_b_d    = sb_d ? -b : b;
    div_zero_d = is_div(op) && (b == '0);
    div_ovf_d  = is_div(op) && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    // On signed overflow the quotient equals the dividend (MIN) and the remainder is zero.
    if (div_zero_d) special_d = op[1] ? a : '1;
    else            special_d = op[1] ? '0 : a;

    prod_d = {hi_c[UNROLL], lo_c[UNROLL]};
    if (prod_neg_q) prod_d = -prod_d;
    quot_d = prod_neg_q ? -lo_c[UNROLL] : lo_c[UNROLL];
    rem_d  = rem_neg_q  ? -hi_c[UNROLL] : hi_c[UNROLL];

    if (!op_q[2]) result_d = (op_q == MDU_MUL) ? prod_d[XLEN-1:0] : prod_d[2*XLEN-1:XLEN];
    else          result_d = op_q[1] ? rem_d : quot_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      prod_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start) begin
            op_q       <= op;
            prod_neg_q <= sa_d ^ sb_d;
            rem_neg_q  <= sa_d;
            hi_q       <= '0;
            lo_q       <= is_div(op) ? mag_a_d : mag_b_d;
            opnd_q     <= is_div(op) ? mag_b_d : mag_a_d;
            if (div_zero_d || div_ovf_d) begin
              result_q <= special_d;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              cnt_q   <= CW'(N);
              busy_q  <= 1'b1;
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          hi_q  <= hi_c[UNROLL];
          lo_q  <= lo_c[UNROLL];
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            result_q <= result_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench: two units (UNROLL=1 and UNROLL=2) share stimulus and are
// compared every cycle against a timing/arithmetic reference model.
module tb_mdu_iterative;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic        busy0, done0, busy2, done2;
  logic [31:0] res0, res2;

  always #5 clk = ~clk;

  mdu_iterative #(.XLEN(32), .UNROLL(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy0), .done(done0), .result(res0)
  );

  mdu_iterative #(.XLEN(32), .UNROLL(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy2), .done(done2), .result(res2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_fn(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'h0, x});
    uy = longint'({32'h0, y});
    case (f)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        p = sx / sy; return p[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
        p = sx % sy; return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    return (f[2] && y == 0) ||
           ((f == 3'd4 || f == 3'd6) && x == 32'h80000000 && y == 32'hFFFFFFFF);
  endfunction

  // Reference model: per unit, cycles of BUSY remaining, the done pulse and the visible result.
  int          m_left [2];
  logic        m_done [2];
  logic [31:0] m_res  [2];
  logic [31:0] m_pend [2];

  always @(posedge clk or negedge rstn) begin
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        m_left[k] <= 0;
        m_done[k] <= 1'b0;
        m_res[k]  <= 32'h0;
        m_pend[k] <= 32'h0;
      end else if (flush) begin
        m_left[k] <= 0;
        m_done[k] <= 1'b0;
      end else if (m_left[k] > 0) begin
        m_left[k] <= m_left[k] - 1;
        m_done[k] <= (m_left[k] == 1);
        if (m_left[k] == 1) m_res[k] <= m_pend[k];
      end else begin
        m_done[k] <= 1'b0;
        if (start) begin
          if (is_special(op, a, b)) begin
            m_done[k] <= 1'b1;
            m_res[k]  <= ref_fn(op, a, b);
          end else begin
            m_left[k] <= (k == 0) ? 32 : 16;
            m_pend[k] <= ref_fn(op, a, b);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("cyc_busy1", {31'b0, busy0}, {31'b0, m_left[0] > 0});
      chk("cyc_done1", {31'b0, done0}, {31'b0, m_done[0]});
      chk("cyc_res1",  res0, m_res[0]);
      chk("cyc_busy2", {31'b0, busy2}, {31'b0, m_left[1] > 0});
      chk("cyc_done2", {31'b0, done2}, {31'b0, m_done[1]});
      chk("cyc_res2",  res2, m_res[1]);
    end
  end

  // Issue one op; poke > 0 fires a second (to-be-ignored) start in that cycle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int poke);
    int          cyc, lat0, lat2, nbusy;
    logic [31:0] r0, r2;
    bit          spec;
    spec = is_special(f, x, y);
    r0 = 'x;
    r2 = 'x;
    @(negedge clk);
    start = 1'b1; op = f; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    cyc = 1; lat0 = 0; lat2 = 0; nbusy = 0;
    while ((lat0 == 0 || lat2 == 0) && cyc < 100) begin
      if (busy0) nbusy++;
      if (done0 && lat0 == 0) begin lat0 = cyc; r0 = res0; end
      if (done2 && lat2 == 0) begin lat2 = cyc; r2 = res2; end
      start = (poke > 0 && cyc == poke);
      if (start) begin op = 3'(f + 3'd5); a = $urandom; b = $urandom_range(1, 9); end
      if (lat0 == 0 || lat2 == 0) begin @(negedge clk); cyc++; end
    end
    start = 1'b0;
    chk("lat_u1", 32'(lat0), spec ? 32'd1 : 32'd33);
    chk("lat_u2", 32'(lat2), spec ? 32'd1 : 32'd17);
    chk("res_u1", r0, exp);
    chk("res_u2", r2, exp);
    chk("busy_cycles", 32'(nbusy), spec ? 32'd0 : 32'd32);
    $display("op=%0d a=%h b=%h res1=%h res2=%h lat1=%0d lat2=%0d", f, x, y, r0, r2, lat0, lat2);
  endtask

  task automatic flush_test(input logic [31:0] prev);
    int ndone;
    ndone = 0;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      if (done0 || done2) ndone++;
      if (cyc == 11) begin
        chk("flush_busy1", {31'b0, busy0}, 32'd0);
        chk("flush_busy2", {31'b0, busy2}, 32'd0);
      end
      flush = (cyc == 10);
      @(negedge clk);
    end
    chk("flush_no_done", 32'(ndone), 32'd0);
    chk("flush_res1", res0, prev);
    chk("flush_res2", res2, prev);
    $display("op=0 a=00000003 b=00000005 flushed res1=%h res2=%h", res0, res2);
  endtask

  task automatic b2b_test();
    int cyc, first, second;
    cyc = 1; first = 0; second = 0;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'hFFFFFFFD;
    @(negedge clk);
    start = 1'b0;
    while (second == 0 && cyc < 150) begin
      start = 1'b0;
      if (done0 && first == 0) begin
        first = cyc;
        chk("b2b_res_first", res0, 32'hFFFFFFEB);
        start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
      end else if (done0 && first != 0) begin
        second = cyc;
      end
      if (second == 0) begin @(negedge clk); cyc++; end
    end
    start = 1'b0;
    chk("b2b_first_cycle", 32'(first), 32'd33);
    chk("b2b_second_cycle", 32'(second), 32'd66);
    chk("b2b_res_second", res0, 32'd14);
    $display("back-to-back MUL then DIVU done1=%0d done2=%0d res=%h", first, second, res0);
  endtask

  task automatic reset_test();
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 12; cyc++) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_busy1", {31'b0, busy0}, 32'd0);
    chk("rst_done1", {31'b0, done0}, 32'd0);
    chk("rst_res1", res0, 32'd0);
    chk("rst_busy2", {31'b0, busy2}, 32'd0);
    chk("rst_res2", res2, 32'd0);
    $display("async reset in cycle 12 res1=%h res2=%h", res0, res2);
    @(negedge clk);
    #2 rstn = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] x, y;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy0}, 32'd0);
    chk("reset_done", {31'b0, done0}, 32'd0);
    chk("reset_result", res0, 32'd0);
    #2 rstn = 1'b1;

    run_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0);
    run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 0);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0);
    run_op(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0);
    run_op(3'd5, 32'd100,      32'd7,        32'd14,       0);
    run_op(3'd7, 32'd100,      32'd7,        32'd2,        0);
    run_op(3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 0);
    run_op(3'd6, 32'd5,        32'd0,        32'd5,        0);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0);
    run_op(3'd5, 32'hFFFFFFFF, 32'd3,        32'h55555555, 0);
    flush_test(32'h55555555);
    run_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 5);
    b2b_test();
    reset_test();

    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = 32'($urandom_range(1, 20));
        3: y = -32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(f, x, y, ref_fn(f, x, y), 0);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
